// File: rtl/out_port_arb.sv
// out_port_arb: switch arbiter for one output of the 5-port wormhole router.
// It finds which inputs want this output, picks one of them round-robin, and
// locks the output to that input until its tail flit passes. Every flit
// transfer also needs a free downstream credit.

// Per-input request decode: does this input's current flit target this output?
module out_port_arb_match #(
    parameter logic [2:0] PORT_ID = 3'b000
) (
    input  logic       valid,
    input  logic [2:0] dst,
    output logic       hit
);
    // Codes 101..111 never equal a legal PORT_ID, so they never match.
    assign hit = valid && (dst == PORT_ID);
endmodule

module out_port_arb #(
    parameter logic [2:0] PORT_ID = 3'b000,
    parameter int         CREDITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  req_valid,
    input  logic [14:0] req_dst,
    input  logic [4:0]  flit_tail,
    input  logic        credit_in,
    output logic [4:0]  grant,
    output logic [2:0]  xbar_sel,
    output logic        xfer,
    output logic [3:0]  credits,
    output logic        credit_err
);
    localparam int         NUM_IN   = 5;
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [2:0]  ptr, ptr_nxt;
    logic [4:0]  grant_nxt;
    logic [2:0]  sel_nxt;
    logic [NUM_IN-1:0] hit;
    logic        any_req;
    logic [2:0]  winner;
    logic [3:0]  rr_idx;
    logic        cred_nz;
    logic        cred_full;

    // One request decoder per input lane.
    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        out_port_arb_match #(.PORT_ID(PORT_ID)) u_match (
            .valid (req_valid[g]),
            .dst   (req_dst[3*g +: 3]),
            .hit   (hit[g])
        );
    end

    assign cred_nz   = (credits != 4'd0);
    assign cred_full = (credits == CRED_MAX);

    // xbar_sel holds the owner while LOCKED. Requests from other inputs do not matter here.
    assign xfer = (state == LOCKED) && req_valid[xbar_sel] && cred_nz;

    // Round-robin search: the first requester found at ptr, ptr+1, ... (mod 5) wins.
    always_comb begin
        any_req = 1'b0;
        winner  = ptr;
        rr_idx  = 4'd0;
        for (int k = 0; k < NUM_IN; k++) begin
            rr_idx = {1'b0, ptr} + 4'(k);
            if (rr_idx >= 4'd5)
                rr_idx = rr_idx - 4'd5;
            if (!any_req && hit[rr_idx[2:0]]) begin
                any_req = 1'b1;
                winner  = rr_idx[2:0];
            end
        end
    end

    // Next state of the FSM: lock onto the winner, then release after the tail transfers.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        sel_nxt   = xbar_sel;
        case (state)
            IDLE: begin
                if (any_req && cred_nz) begin
                    state_nxt = LOCKED;
                    grant_nxt = 5'b00001 << winner;
                    sel_nxt   = winner;
                end
            end
            LOCKED: begin
                // On release xbar_sel keeps its value. Only grant drops.
                if (xfer && flit_tail[xbar_sel]) begin
                    state_nxt = IDLE;
                    grant_nxt = 5'b00000;
                    ptr_nxt   = (xbar_sel == 3'd4) ? 3'd0 : xbar_sel + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointer and the registered grant/select outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            grant    <= 5'b00000;
            xbar_sel <= 3'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant    <= grant_nxt;
            xbar_sel <= sel_nxt;
        end
    end

    // Saturating downstream credit counter with an overflow pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits    <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            credit_err <= 1'b0;
            case ({xfer, credit_in})
                2'b10: credits <= credits - 4'd1;
                2'b01: begin
                    if (cred_full)
                        credit_err <= 1'b1;
                    else
                        credits <= credits + 4'd1;
                end
                default: credits <= credits;
            endcase
        end
    end
endmodule

// File: tb/tb_out_port_arb.sv
// tb_out_port_arb: directed scenarios plus random traffic, checked every
// cycle against a behavioural model of the output arbiter.
module tb_out_port_arb;
    localparam logic [2:0] PORT = 3'b010;
    localparam int         CRED = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  req_valid;
    logic [14:0] req_dst;
    logic [4:0]  flit_tail;
    logic        credit_in;
    logic [4:0]  grant;
    logic [2:0]  xbar_sel;
    logic        xfer;
    logic [3:0]  credits;
    logic        credit_err;

    out_port_arb #(.PORT_ID(PORT), .CREDITS(CRED)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_dst(req_dst),
        .flit_tail(flit_tail), .credit_in(credit_in), .grant(grant),
        .xbar_sel(xbar_sel), .xfer(xfer), .credits(credits), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Traffic sources, one per input lane
    int         len[5];
    int         sent[5];
    bit         pend[5];
    bit         gap[5];
    bit         rearm[5];
    logic [2:0] dst[5];
    bit         auto_cin;

    // DUT outputs captured in the most recent step
    logic [4:0] s_grant;
    logic       s_xfer;
    logic [3:0] s_cred;
    logic       s_err;
    logic [2:0] s_sel;

    task automatic start_pkt(input int l, input int n, input logic [2:0] d);
        pend[l] = 1'b1;
        len[l]  = n;
        sent[l] = 0;
        dst[l]  = d;
    endtask

    task automatic step(input bit cin, input bit rst);
        int o;
        @(negedge clk);
        reset     = rst;
        credit_in = cin || (auto_cin && grant != 5'b0);
        for (int i = 0; i < 5; i++) begin
            req_valid[i]       = pend[i] && !gap[i];
            flit_tail[i]       = pend[i] && (sent[i] == len[i] - 1);
            req_dst[3*i +: 3]  = dst[i];
        end
        #3;
        s_grant = grant; s_xfer = xfer; s_cred = credits; s_err = credit_err; s_sel = xbar_sel;
        if (xfer === 1'b1 && !rst) begin
            o = int'(xbar_sel);
            sent[o]++;
            if (sent[o] >= len[o]) begin
                pend[o] = 1'b0;
                if (rearm[o]) start_pkt(o, 1, PORT);
            end
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 5; i++) begin
            pend[i] = 1'b0; gap[i] = 1'b0; rearm[i] = 1'b0; dst[i] = PORT; sent[i] = 0; len[i] = 1;
        end
    endtask

    // Behavioural model: owner/pointer/credit count as plain integers
    bit         m_ok = 1'b0;
    bit         m_locked;
    int         m_owner, m_ptr, m_cred, m_sel;
    bit         m_err;
    logic [4:0] e_grant;
    bit         e_xfer;

    // Compare process: check this cycle's outputs, then advance the model
    always begin
        int c0, idx;
        bit found;
        @(negedge clk);
        #2;
        e_xfer = m_locked && (req_valid[m_owner] === 1'b1) && (m_cred > 0);
        if (m_ok) begin
            e_grant = m_locked ? (5'b00001 << m_owner) : 5'b00000;
            check("grant", 32'(grant), 32'(e_grant));
            check("xbar_sel", 32'(xbar_sel), 32'(m_sel));
            check("xfer", 32'(xfer), 32'(e_xfer));
            check("credits", 32'(credits), 32'(m_cred));
            check("credit_err", 32'(credit_err), 32'(m_err));
        end
        if (reset === 1'b1) begin
            m_ok = 1'b1; m_locked = 1'b0; m_owner = 0; m_ptr = 0;
            m_sel = 0; m_cred = CRED; m_err = 1'b0;
        end else if (m_ok) begin
            c0    = m_cred;
            m_err = credit_in && !e_xfer && (c0 == CRED);
            m_cred = c0 - int'(e_xfer) + int'(credit_in);
            if (m_cred > CRED) m_cred = CRED;
            if (m_locked) begin
                if (e_xfer && flit_tail[m_owner]) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % 5;
                end
            end else if (c0 > 0) begin
                found = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    idx = (m_ptr + k) % 5;
                    if (!found && req_valid[idx] && req_dst[3*idx +: 3] == PORT) begin
                        found = 1'b1; m_locked = 1'b1; m_owner = idx; m_sel = idx;
                    end
                end
            end
        end
    end

    logic [4:0] g[10];
    logic       x[10];
    int         nx;

    initial begin
        reset = 1'b1; credit_in = 1'b0; req_valid = '0; flit_tail = '0; req_dst = '0;
        auto_cin = 1'b0;
        clear_src();
        step(0, 1);
        step(0, 1);
        check("reset_grant", 32'(s_grant), 32'h0);
        check("reset_sel", 32'(s_sel), 32'h0);
        check("reset_credits", 32'(s_cred), 32'(CRED));
        check("reset_err", 32'(s_err), 32'h0);

        // Single-flit packet from N
        start_pkt(2, 1, PORT);
        step(0, 0); check("sf_c0_grant", 32'(s_grant), 32'h0);
        step(0, 0); check("sf_c1_grant", 32'(s_grant), 32'h04);
                    check("sf_c1_xfer", 32'(s_xfer), 32'h1);
                    check("sf_c1_cred", 32'(s_cred), 32'h4);
        step(0, 0); check("sf_c2_grant", 32'(s_grant), 32'h0);
                    check("sf_c2_cred", 32'(s_cred), 32'h3);
        step(1, 0); check("sf_c3_cred", 32'(s_cred), 32'h3);
        step(0, 0); check("sf_c4_cred", 32'(s_cred), 32'h4);

        // Round-robin among E, N and J, credits kept full
        step(0, 1);
        auto_cin = 1'b1;
        rearm[0] = 1; rearm[2] = 1; rearm[4] = 1;
        start_pkt(0, 1, PORT); start_pkt(2, 1, PORT); start_pkt(4, 1, PORT);
        for (int c = 0; c < 8; c++) begin
            step(0, 0); g[c] = s_grant;
        end
        check("rr_c0", 32'(g[0]), 32'h00); check("rr_c1", 32'(g[1]), 32'h01);
        check("rr_c2", 32'(g[2]), 32'h00); check("rr_c3", 32'(g[3]), 32'h04);
        check("rr_c4", 32'(g[4]), 32'h00); check("rr_c5", 32'(g[5]), 32'h10);
        check("rr_c6", 32'(g[6]), 32'h00); check("rr_c7", 32'(g[7]), 32'h01);
        auto_cin = 1'b0;
        clear_src();

        // Wormhole lock: W has 3 flits with a 2-cycle gap; S waits
        step(0, 1);
        start_pkt(1, 3, PORT); start_pkt(3, 1, PORT);
        for (int c = 0; c < 8; c++) begin
            gap[1] = (c == 2 || c == 3);
            step(0, 0); g[c] = s_grant; x[c] = s_xfer;
        end
        gap[1] = 1'b0;
        check("wh_g1", 32'(g[1]), 32'h02); check("wh_x1", 32'(x[1]), 32'h1);
        check("wh_g2", 32'(g[2]), 32'h02); check("wh_x2", 32'(x[2]), 32'h0);
        check("wh_g3", 32'(g[3]), 32'h02); check("wh_x3", 32'(x[3]), 32'h0);
        check("wh_x5", 32'(x[5]), 32'h1);
        check("wh_g6", 32'(g[6]), 32'h00);
        check("wh_g7", 32'(g[7]), 32'h08);
        clear_src();

        // Credit stall: 6-flit packet with only 4 credits
        step(0, 1);
        start_pkt(1, 6, PORT);
        nx = 0;
        for (int c = 0; c < 9; c++) begin step(0, 0); nx += int'(s_xfer); end
        check("stall_xfers", 32'(nx), 32'd4);
        check("stall_cred", 32'(s_cred), 32'h0);
        check("stall_xfer_low", 32'(s_xfer), 32'h0);
        step(1, 0);
        nx = 0;
        for (int c = 0; c < 4; c++) begin step(0, 0); nx += int'(s_xfer); end
        check("stall_one_more", 32'(nx), 32'd1);
        check("stall_cred2", 32'(s_cred), 32'h0);
        for (int c = 0; c < 20 && pend[1]; c++) step(1, 0);
        check("stall_drained", 32'(pend[1]), 32'h0);
        clear_src();

        // Simultaneous xfer + credit_in, then overflow
        step(0, 1);
        start_pkt(1, 3, PORT);
        step(0, 0); step(0, 0); step(0, 0);
        step(1, 0); check("sim_pre_cred", 32'(s_cred), 32'h2);
                    check("sim_tail_xfer", 32'(s_xfer), 32'h1);
        step(0, 0); check("sim_cred", 32'(s_cred), 32'h2);
        step(1, 0); step(1, 0);
        step(1, 0); check("ovf_full", 32'(s_cred), 32'h4);
                    check("ovf_err_pre", 32'(s_err), 32'h0);
        step(0, 0); check("ovf_cred", 32'(s_cred), 32'h4);
                    check("ovf_err", 32'(s_err), 32'h1);
        step(0, 0); check("ovf_err_clr", 32'(s_err), 32'h0);

        // Reset mid-packet, then a destination code that never matches
        step(0, 1);
        start_pkt(1, 5, PORT);
        step(0, 0); step(0, 0); step(0, 0);
        check("rst_locked", 32'(s_grant), 32'h02);
        clear_src();
        step(0, 1);
        step(0, 0); check("rst_grant", 32'(s_grant), 32'h0);
                    check("rst_cred", 32'(s_cred), 32'(CRED));
        start_pkt(3, 1, 3'b111);
        nx = 0;
        for (int c = 0; c < 6; c++) begin step(0, 0); nx += int'(s_grant != 5'b0); end
        check("mismatch_never", 32'(nx), 32'd0);
        clear_src();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            bit rst, cin;
            for (int i = 0; i < 5; i++) begin
                if (!pend[i] && $urandom_range(3) == 0)
                    start_pkt(i, int'($urandom_range(4, 1)),
                              ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : PORT);
                else if (pend[i] && dst[i] != PORT && $urandom_range(3) == 0)
                    pend[i] = 1'b0;
                gap[i] = ($urandom_range(4) == 0);
            end
            rst = ($urandom_range(299) == 0);
            cin = ($urandom_range(2) == 0);
            if (rst) clear_src();
            step(cin, rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
